// File: rtl/fetch_decode_reg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_decode_reg
//  Brief    : IF/ID elastic pipeline register. It has an output slot and a
//             skid slot, inserts NOP bubbles when empty, and flushes on redirect.
//             Optional FD_PERF_CNT_EN adds stall/bubble performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_decode_reg #(
    parameter int          TD       = 1,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_valid,
    output logic        f_ready,
    input  logic [31:0] f_inst,
    input  logic [31:0] f_pc_plus_4,
    input  logic        flush,
    input  logic        d_ready,
    output logic        d_valid,
    output logic [31:0] fd_Inst,
    output logic [25:0] fd_Inst_25_0,
    output logic [31:0] fd_br_signext_sl2,
    output logic [31:0] fd_pc_plus_4
`ifdef FD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    // TD carries no modelled delay here; registers update at the clock edge.
    if (TD < 0) begin : g_td_negative
    end

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_out_inst;
    logic [31:0] r_out_pc;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic [31:0] w_out_inst_nxt;
    logic [31:0] w_out_pc_nxt;
    logic [31:0] w_skid_inst_nxt;
    logic [31:0] w_skid_pc_nxt;
    logic        w_push;
    logic        w_pop;

    // Handshake flags come straight from the state register: no d_ready -> f_ready path.
    assign f_ready = (r_state != c_FULL);
    assign d_valid = (r_state != c_EMPTY);
    assign w_push  = f_valid & f_ready;
    assign w_pop   = d_valid & d_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_out_inst_nxt  = r_out_inst;
        w_out_pc_nxt    = r_out_pc;
        w_skid_inst_nxt = r_skid_inst;
        w_skid_pc_nxt   = r_skid_pc;
        case (r_state)
            c_EMPTY: begin
                if (w_push) begin
                    w_state_nxt    = c_ONE;
                    w_out_inst_nxt = f_inst;
                    w_out_pc_nxt   = f_pc_plus_4;
                end
            end
            c_ONE: begin
                if (w_push && w_pop) begin
                    w_out_inst_nxt = f_inst;
                    w_out_pc_nxt   = f_pc_plus_4;
                end else if (w_push) begin
                    w_state_nxt     = c_FULL;
                    w_skid_inst_nxt = f_inst;
                    w_skid_pc_nxt   = f_pc_plus_4;
                end else if (w_pop) begin
                    w_state_nxt = c_EMPTY;
                end
            end
            c_FULL: begin
                if (w_pop) begin
                    w_state_nxt    = c_ONE;
                    w_out_inst_nxt = r_skid_inst;
                    w_out_pc_nxt   = r_skid_pc;
                end
            end
            default: begin
                w_state_nxt = c_EMPTY;
            end
        endcase
        // Redirect discards everything, including a word offered this cycle.
        if (flush) begin
            w_state_nxt     = c_EMPTY;
            w_out_inst_nxt  = 32'h0;
            w_out_pc_nxt    = 32'h0;
            w_skid_inst_nxt = 32'h0;
            w_skid_pc_nxt   = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_EMPTY;
            r_out_inst  <= 32'h0;
            r_out_pc    <= 32'h0;
            r_skid_inst <= 32'h0;
            r_skid_pc   <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_inst  <= w_out_inst_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_skid_inst <= w_skid_inst_nxt;
            r_skid_pc   <= w_skid_pc_nxt;
        end
    end

    assign fd_Inst           = d_valid ? r_out_inst : NOP_INST;
    assign fd_pc_plus_4      = d_valid ? r_out_pc : 32'h0;
    assign fd_Inst_25_0      = fd_Inst[25:0];
    assign fd_br_signext_sl2 = {{14{fd_Inst[15]}}, fd_Inst[15:0], 2'b00};

`ifdef FD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Counters wrap naturally; flush deliberately leaves them running.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt  <= 32'h0;
            r_bubble_cnt <= 32'h0;
        end else begin
            if (f_valid && !f_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!d_valid && d_ready) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_decode_reg
//  Brief    : Self-checking bench for fetch_decode_reg (vector table + queue model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_decode_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_inst;
    logic [31:0] f_pc_plus_4;
    logic        flush;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] fd_Inst;
    logic [25:0] fd_Inst_25_0;
    logic [31:0] fd_br_signext_sl2;
    logic [31:0] fd_pc_plus_4;
`ifdef FD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    always #5 clk = ~clk;

    fetch_decode_reg #(
        .TD       (1),
        .NOP_INST (32'h0000_0000)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .f_valid           (f_valid),
        .f_ready           (f_ready),
        .f_inst            (f_inst),
        .f_pc_plus_4       (f_pc_plus_4),
        .flush             (flush),
        .d_ready           (d_ready),
        .d_valid           (d_valid),
        .fd_Inst           (fd_Inst),
        .fd_Inst_25_0      (fd_Inst_25_0),
        .fd_br_signext_sl2 (fd_br_signext_sl2),
        .fd_pc_plus_4      (fd_pc_plus_4)
`ifdef FD_PERF_CNT_EN
        ,
        .stall_cnt         (stall_cnt),
        .bubble_cnt        (bubble_cnt)
`endif
    );

    typedef struct {
        logic        fv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        dr;
        logic        fl;
        logic        exp_dv;
        logic        exp_fr;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        logic [31:0] exp_br;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    localparam int c_NVEC = 22;

    vec_t vecs[c_NVEC];
    ent_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_br(input logic [31:0] i);
        return {{14{i[15]}}, i[15:0], 2'b00};
    endfunction

    task automatic set_vec(input int idx, input logic fv, input logic [31:0] inst,
                           input logic [31:0] pc, input logic dr, input logic fl,
                           input logic edv, input logic efr, input logic [31:0] einst,
                           input logic [31:0] epc, input logic [31:0] ebr);
        vecs[idx] = '{fv, inst, pc, dr, fl, edv, efr, einst, epc, ebr};
    endtask

    task automatic drive(input logic fv, input logic [31:0] inst, input logic [31:0] pc,
                         input logic dr, input logic fl);
        @(negedge clk);
        f_valid     = fv;
        f_inst      = inst;
        f_pc_plus_4 = pc;
        d_ready     = dr;
        flush       = fl;
        #1;
    endtask

    // Compare against the queue model, then advance it across the coming edge.
    task automatic score();
        ent_t e;
        logic accept;
        check1("sb_d_valid", d_valid, sb.size() > 0);
        check1("sb_f_ready", f_ready, sb.size() < 2);
        if (sb.size() == 0) begin
            check32("sb_nop_inst", fd_Inst, 32'h0);
            check32("sb_nop_pc", fd_pc_plus_4, 32'h0);
        end else if (d_ready) begin
            e = sb[0];
            check32("sb_inst", fd_Inst, e.inst);
            check32("sb_pc", fd_pc_plus_4, e.pc);
            check32("sb_br", fd_br_signext_sl2, ref_br(e.inst));
            check32("sb_i26", {6'b0, fd_Inst_25_0}, {6'b0, e.inst[25:0]});
        end
        accept = f_valid && (sb.size() < 2);
        if (flush) begin
            sb.delete();
        end else begin
            if (sb.size() > 0 && d_ready) void'(sb.pop_front());
            if (accept) sb.push_back('{f_inst, f_pc_plus_4});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b0;
        f_valid     = 1'b1;
        f_inst      = 32'hDEAD_BEEF;
        f_pc_plus_4 = 32'h0000_0F00;
        d_ready     = 1'b0;
        flush       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b1;
        f_valid = 1'b0;
        sb.delete();
        #1;
        check1("rst_d_valid", d_valid, 1'b0);
        check1("rst_f_ready", f_ready, 1'b1);
        check32("rst_inst", fd_Inst, 32'h0);
        check32("rst_pc", fd_pc_plus_4, 32'h0);
        check32("rst_br", fd_br_signext_sl2, 32'h0);
        check32("rst_i26", {6'b0, fd_Inst_25_0}, 32'h0);
`ifdef FD_PERF_CNT_EN
        check32("rst_stall_cnt", stall_cnt, 32'h0);
        check32("rst_bubble_cnt", bubble_cnt, 32'h0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          fv  inst           pc            dr fl  dv fr exp_inst      exp_pc        exp_br
        set_vec( 0, 1, 32'h1000_FFFF, 32'h0000_0104, 1, 0,  0, 1, 32'h0,        32'h0,        32'h0);
        set_vec( 1, 0, 32'h0,         32'h0,         1, 0,  1, 1, 32'h1000_FFFF, 32'h0000_0104, 32'hFFFF_FFFC);
        set_vec( 2, 1, 32'h2001_0001, 32'h0000_0200, 0, 0,  0, 1, 32'h0,        32'h0,        32'h0);
        set_vec( 3, 1, 32'h2002_0002, 32'h0000_0204, 0, 0,  1, 1, 32'h2001_0001, 32'h0000_0200, 32'h0000_0004);
        set_vec( 4, 1, 32'h2003_0003, 32'h0000_0208, 0, 0,  1, 0, 32'h2001_0001, 32'h0000_0200, 32'h0000_0004);
        set_vec( 5, 1, 32'h2003_0003, 32'h0000_0208, 1, 0,  1, 0, 32'h2001_0001, 32'h0000_0200, 32'h0000_0004);
        set_vec( 6, 1, 32'h2003_0003, 32'h0000_0208, 1, 0,  1, 1, 32'h2002_0002, 32'h0000_0204, 32'h0000_0008);
        set_vec( 7, 0, 32'h0,         32'h0,         1, 0,  1, 1, 32'h2003_0003, 32'h0000_0208, 32'h0000_000C);
        set_vec( 8, 0, 32'h0,         32'h0,         0, 0,  0, 1, 32'h0,        32'h0,        32'h0);
        set_vec( 9, 1, 32'h3001_0001, 32'h0000_0300, 0, 0,  0, 1, 32'h0,        32'h0,        32'h0);
        set_vec(10, 1, 32'h3002_0002, 32'h0000_0304, 0, 0,  1, 1, 32'h3001_0001, 32'h0000_0300, 32'h0000_0004);
        set_vec(11, 1, 32'h3003_0003, 32'h0000_0308, 0, 1,  1, 0, 32'h3001_0001, 32'h0000_0300, 32'h0000_0004);
        set_vec(12, 0, 32'h0,         32'h0,         1, 0,  0, 1, 32'h0,        32'h0,        32'h0);
        set_vec(13, 1, 32'h3004_0004, 32'h0000_030C, 1, 1,  0, 1, 32'h0,        32'h0,        32'h0);
        set_vec(14, 0, 32'h0,         32'h0,         1, 0,  0, 1, 32'h0,        32'h0,        32'h0);
        set_vec(15, 1, 32'h0000_8000, 32'h0000_0400, 0, 0,  0, 1, 32'h0,        32'h0,        32'h0);
        set_vec(16, 0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h0000_8000, 32'h0000_0400, 32'hFFFE_0000);
        set_vec(17, 0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h0000_8000, 32'h0000_0400, 32'hFFFE_0000);
        set_vec(18, 0, 32'h0,         32'h0,         1, 0,  1, 1, 32'h0000_8000, 32'h0000_0400, 32'hFFFE_0000);
        set_vec(19, 1, 32'h0000_0011, 32'h0000_0500, 0, 0,  0, 1, 32'h0,        32'h0,        32'h0);
        set_vec(20, 1, 32'h0000_0022, 32'h0000_0504, 1, 1,  1, 1, 32'h0000_0011, 32'h0000_0500, 32'h0000_0044);
        set_vec(21, 0, 32'h0,         32'h0,         0, 0,  0, 1, 32'h0,        32'h0,        32'h0);

        rst         = 1'b1;
        f_valid     = 1'b0;
        f_inst      = 32'h0;
        f_pc_plus_4 = 32'h0;
        flush       = 1'b0;
        d_ready     = 1'b0;
        do_reset();

        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i].fv, vecs[i].inst, vecs[i].pc, vecs[i].dr, vecs[i].fl);
            check1("vec_d_valid", d_valid, vecs[i].exp_dv);
            check1("vec_f_ready", f_ready, vecs[i].exp_fr);
            check32("vec_inst", fd_Inst, vecs[i].exp_inst);
            check32("vec_pc", fd_pc_plus_4, vecs[i].exp_pc);
            check32("vec_br", fd_br_signext_sl2, vecs[i].exp_br);
            check32("vec_i26", {6'b0, fd_Inst_25_0}, {6'b0, vecs[i].exp_inst[25:0]});
            score();
        end

        // Streaming: one word per cycle, occupancy must stay at one.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 32'hA000_0000 + 32'(k), 32'(4 * k), 1'b1, 1'b0);
            if (k > 1) begin
                check32("stream_pc", fd_pc_plus_4, 32'(4 * (k - 1)));
                check1("stream_f_ready", f_ready, 1'b1);
            end
            score();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check32("stream_last_pc", fd_pc_plus_4, 32'd32);
        score();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        score();

        // Counter sequence: 2 bubble cycles, fill, then 3 stalled offers.
        do_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        score();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        score();
        drive(1'b1, 32'h4001_0001, 32'h0000_0600, 1'b0, 1'b0);
        score();
        drive(1'b1, 32'h4002_0002, 32'h0000_0604, 1'b0, 1'b0);
        score();
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 32'h4003_0003, 32'h0000_0608, 1'b0, 1'b0);
            score();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check32("full_hold_inst", fd_Inst, 32'h4001_0001);
`ifdef FD_PERF_CNT_EN
        check32("stall_cnt", stall_cnt, 32'd3);
        check32("bubble_cnt", bubble_cnt, 32'd2);
`endif
        score();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
